// File: rtl/sme_job_arbiter.sv
// sme_job_arbiter: shares one string-match engine between two requesters.
// Each requester byte-loads a private string/pattern job; pending jobs are
// granted round-robin, streamed to the engine, and the engine result (or a
// timeout / bad-job status) is returned to the job owner as a one-cycle pulse.
module sme_job_arbiter #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_is_pat,
  input  logic [1:0]  req_last,
  input  logic [15:0] req_data,
  output logic [7:0]  eng_chardata,
  output logic        eng_isstring,
  output logic        eng_ispattern,
  input  logic        eng_valid,
  input  logic        eng_match,
  input  logic [4:0]  eng_match_index,
  output logic [1:0]  resp_valid,
  output logic        resp_match,
  output logic [4:0]  resp_index,
  output logic [1:0]  resp_status
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SIW = $clog2(STR_MAX);
  localparam int PIW = $clog2(PAT_MAX);
  localparam int TW  = $clog2(TIMEOUT);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BAD     = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_STR,
    S_SEND_PAT,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_n;

  logic [STR_MAX*8-1:0] str_buf [2];
  logic [PAT_MAX*8-1:0] pat_buf [2];
  logic [SLW-1:0]       str_len [2];
  logic [PLW-1:0]       pat_len [2];
  logic [1:0]           pending;

  logic           owner, owner_n;
  logic           last_grant, last_grant_n;
  logic [SIW-1:0] cnt, cnt_n;
  logic [TW-1:0]  wait_cnt, wait_n;
  logic           grant;

  logic [7:0] chardata_n;
  logic       isstring_n, ispattern_n;
  logic [1:0] resp_valid_n;
  logic       match_n;
  logic [4:0] index_n;
  logic [1:0] status_n;

  // A requester may load only while it has no pending or in-service job;
  // pending stays set until the response cycle clears it.
  assign req_ready = ~pending;

  // Round-robin pick: on a tie prefer the requester not granted last time.
  assign grant = (pending == 2'b11) ? ~last_grant : pending[1];

  // Next-state, next engine strobes and next response fields.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    wait_n       = wait_cnt;
    match_n      = 1'b0;
    index_n      = '0;
    status_n     = ST_OK;
    unique case (state)
      S_IDLE: begin
        if (pending != 2'b00) begin
          owner_n      = grant;
          last_grant_n = grant;
          cnt_n        = '0;
          if (str_len[grant] == '0 || pat_len[grant] == '0) begin
            state_n  = S_RESP;
            status_n = ST_BAD;
          end else begin
            state_n = S_SEND_STR;
          end
        end
      end
      S_SEND_STR: begin
        if (SLW'(cnt) == str_len[owner] - SLW'(1)) begin
          state_n = S_SEND_PAT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + SIW'(1);
        end
      end
      S_SEND_PAT: begin
        if (PLW'(cnt) == pat_len[owner] - PLW'(1)) begin
          state_n = S_WAIT;
          wait_n  = '0;
        end else begin
          cnt_n = cnt + SIW'(1);
        end
      end
      S_WAIT: begin
        if (eng_valid) begin
          state_n  = S_RESP;
          match_n  = eng_match;
          index_n  = eng_match ? eng_match_index : 5'd0;
          status_n = ST_OK;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          state_n  = S_RESP;
          status_n = ST_TIMEOUT;
        end else begin
          wait_n = wait_cnt + TW'(1);
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Engine and response outputs are registered, so they are derived from
    // the next state: the strobe is visible during the cycle spent in that state.
    isstring_n   = (state_n == S_SEND_STR);
    ispattern_n  = (state_n == S_SEND_PAT);
    chardata_n   = '0;
    if (isstring_n)
      chardata_n = str_buf[owner_n][8*cnt_n +: 8];
    else if (ispattern_n)
      chardata_n = pat_buf[owner_n][8*cnt_n[PIW-1:0] +: 8];
    resp_valid_n = (state_n == S_RESP) ? (owner_n ? 2'b10 : 2'b01) : 2'b00;
  end

  // FSM state, arbitration history and registered engine/response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      cnt           <= '0;
      wait_cnt      <= '0;
      eng_chardata  <= '0;
      eng_isstring  <= 1'b0;
      eng_ispattern <= 1'b0;
      resp_valid    <= '0;
      resp_match    <= 1'b0;
      resp_index    <= '0;
      resp_status   <= '0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      last_grant    <= last_grant_n;
      cnt           <= cnt_n;
      wait_cnt      <= wait_n;
      eng_chardata  <= chardata_n;
      eng_isstring  <= isstring_n;
      eng_ispattern <= ispattern_n;
      resp_valid    <= resp_valid_n;
      resp_match    <= (state_n == S_RESP) ? match_n : 1'b0;
      resp_index    <= (state_n == S_RESP) ? index_n : 5'd0;
      resp_status   <= (state_n == S_RESP) ? status_n : 2'd0;
    end
  end

  // Per-requester job loading; the owner's job is dropped in its response cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int unsigned r = 0; r < 2; r++) begin
        str_buf[r] <= '0;
        pat_buf[r] <= '0;
        str_len[r] <= '0;
        pat_len[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < 2; r++) begin
        if (state == S_RESP && owner == 1'(r)) begin
          str_buf[r] <= '0;
          pat_buf[r] <= '0;
          str_len[r] <= '0;
          pat_len[r] <= '0;
          pending[r] <= 1'b0;
        end else if (req_valid[r] && req_ready[r]) begin
          if (req_is_pat[r]) begin
            if (pat_len[r] < PLW'(PAT_MAX)) begin
              pat_buf[r][8*pat_len[r][PIW-1:0] +: 8] <= req_data[8*r +: 8];
              pat_len[r] <= pat_len[r] + PLW'(1);
            end
            if (req_last[r])
              pending[r] <= 1'b1;
          end else if (pat_len[r] == '0 && str_len[r] < SLW'(STR_MAX)) begin
            // String bytes after the pattern has started are dropped.
            str_buf[r][8*str_len[r][SIW-1:0] +: 8] <= req_data[8*r +: 8];
            str_len[r] <= str_len[r] + SLW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sme_job_arbiter.sv
// Bench for sme_job_arbiter: a behavioural engine plus a response scoreboard,
// driven by one task per scenario.
module tb_sme_job_arbiter;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 64;
  localparam int ENG_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_is_pat = '0;
  logic [1:0]  req_last = '0;
  logic [15:0] req_data = '0;
  logic [7:0]  eng_chardata;
  logic        eng_isstring;
  logic        eng_ispattern;
  logic        eng_valid = 1'b0;
  logic        eng_match = 1'b0;
  logic [4:0]  eng_match_index = '0;
  logic [1:0]  resp_valid;
  logic        resp_match;
  logic [4:0]  resp_index;
  logic [1:0]  resp_status;

  always #5 clk = ~clk;

  sme_job_arbiter #(
    .STR_MAX(STR_MAX),
    .PAT_MAX(PAT_MAX),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_is_pat(req_is_pat),
    .req_last(req_last),
    .req_data(req_data),
    .eng_chardata(eng_chardata),
    .eng_isstring(eng_isstring),
    .eng_ispattern(eng_ispattern),
    .eng_valid(eng_valid),
    .eng_match(eng_match),
    .eng_match_index(eng_match_index),
    .resp_valid(resp_valid),
    .resp_match(resp_match),
    .resp_index(resp_index),
    .resp_status(resp_status)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: {resp_valid, match, index, status} plus expected streamed text.
  logic [9:0] q_res[$];
  string      q_s[$];
  string      q_p[$];

  string      seen_s = "";
  string      seen_p = "";
  bit         got_pat = 1'b0;
  bit         eng_on = 1'b1;
  int         lat = 0;
  int         k_eng;
  logic [9:0] e_res;
  string      e_s;
  string      e_p;

  function automatic int find_sub(string s, string p);
    if (s.len() == 0 || p.len() == 0 || p.len() > s.len()) return -1;
    for (int i = 0; i <= s.len() - p.len(); i++)
      if (s.substr(i, i + p.len() - 1) == p) return i;
    return -1;
  endfunction

  function automatic string clip(string s, int n);
    return (s.len() > n) ? s.substr(0, n - 1) : s;
  endfunction

  task automatic expect_job(input int r, input string s, input string p, input bit to);
    string cs = clip(s, STR_MAX);
    string cp = clip(p, PAT_MAX);
    int k;
    logic [1:0] st;
    logic m;
    logic [4:0] ix;
    if (cs.len() == 0 || cp.len() == 0) begin
      st = 2'd2; m = 1'b0; ix = 5'd0; cs = ""; cp = "";
    end else if (to) begin
      st = 2'd1; m = 1'b0; ix = 5'd0;
    end else begin
      k = find_sub(cs, cp);
      st = 2'd0; m = (k >= 0); ix = (k >= 0) ? 5'(k) : 5'd0;
    end
    q_res.push_back({(r == 1) ? 2'b10 : 2'b01, m, ix, st});
    q_s.push_back(cs);
    q_p.push_back(cp);
  endtask

  // Engine model and response scoreboard, both sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = '0;
      seen_s = ""; seen_p = ""; got_pat = 1'b0; lat = 0;
    end else begin
      eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = '0;
      if (resp_valid != 2'b00) begin
        n_cmp++;
        if (q_res.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_resp: resp_valid=%b, required no response", resp_valid);
        end else begin
          e_res = q_res.pop_front();
          e_s = q_s.pop_front();
          e_p = q_p.pop_front();
          if ({resp_valid, resp_match, resp_index, resp_status} !== e_res) begin
            n_err++;
            $display("FAIL resp_fields: got valid=%b match=%b index=%0d status=%0d, required valid=%b match=%b index=%0d status=%0d",
                     resp_valid, resp_match, resp_index, resp_status,
                     e_res[9:8], e_res[7], e_res[6:2], e_res[1:0]);
          end
          n_cmp++;
          if (seen_s != e_s || seen_p != e_p) begin
            n_err++;
            $display("FAIL stream: got str=\"%s\" pat=\"%s\", required str=\"%s\" pat=\"%s\"",
                     seen_s, seen_p, e_s, e_p);
          end
        end
        seen_s = ""; seen_p = ""; got_pat = 1'b0; lat = 0;
      end else begin
        if (eng_isstring) seen_s = $sformatf("%s%c", seen_s, eng_chardata);
        if (eng_ispattern) begin
          seen_p = $sformatf("%s%c", seen_p, eng_chardata);
          got_pat = 1'b1;
        end
        if (!eng_isstring && !eng_ispattern && got_pat && eng_on) begin
          if (lat == ENG_LAT) begin
            k_eng = find_sub(seen_s, seen_p);
            eng_valid = 1'b1;
            eng_match = (k_eng >= 0);
            eng_match_index = (k_eng >= 0) ? 5'(k_eng) : 5'd0;
            got_pat = 1'b0;
            lat = 0;
          end else begin
            lat++;
          end
        end
      end
    end
  end

  task automatic send_byte(input int r, input bit pat, input bit last, input byte d);
    int w = 0;
    req_valid[r] = 1'b1;
    req_is_pat[r] = pat;
    req_last[r] = last;
    req_data[8*r +: 8] = d;
    while (!req_ready[r] && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready[r]) begin
      n_cmp++; n_err++;
      $display("FAIL ready_wait: req_ready[%0d]=0 after %0d cycles, required 1", r, w);
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    req_is_pat[r] = 1'b0;
    req_last[r] = 1'b0;
  endtask

  task automatic load_job(input int r, input string s, input string p);
    for (int i = 0; i < s.len(); i++) send_byte(r, 1'b0, 1'b0, s[i]);
    for (int i = 0; i < p.len(); i++) send_byte(r, 1'b1, (i == p.len() - 1), p[i]);
  endtask

  task automatic drain(output bit ok);
    int w = 0;
    while (q_res.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    ok = (q_res.size() == 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q_res.delete(); q_s.delete(); q_p.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b11) begin n_err++; $display("FAIL rst_ready: got %b, required 11", req_ready); end
    n_cmp++;
    if ({eng_isstring, eng_ispattern, eng_chardata} !== 10'd0) begin
      n_err++; $display("FAIL rst_engine: got isstring=%b ispattern=%b chardata=%h, required 0", eng_isstring, eng_ispattern, eng_chardata);
    end
    n_cmp++;
    if ({resp_valid, resp_match, resp_index, resp_status} !== 10'd0) begin
      n_err++; $display("FAIL rst_resp: got valid=%b match=%b index=%0d status=%0d, required 0", resp_valid, resp_match, resp_index, resp_status);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b11 || resp_valid !== 2'b00) begin
      n_err++; $display("FAIL rst_release: got ready=%b resp_valid=%b, required 11/00", req_ready, resp_valid);
    end
  endtask

  task automatic test_basic();
    int ns = 0;
    int np = 0;
    int w = 0;
    bit ok;
    expect_job(0, "ABCDE", "CD", 1'b0);
    load_job(0, "ABCDE", "CD");
    @(negedge clk);
    n_cmp++;
    if (eng_isstring !== 1'b0 || req_ready[0] !== 1'b0) begin
      n_err++; $display("FAIL basic_t1: got isstring=%b ready0=%b, required 0/0", eng_isstring, req_ready[0]);
    end
    @(negedge clk);
    n_cmp++;
    if ({eng_isstring, eng_chardata} !== {1'b1, 8'h41}) begin
      n_err++; $display("FAIL basic_t2: got isstring=%b chardata=%h, required 1/41", eng_isstring, eng_chardata);
    end
    while (eng_isstring && ns < 100) begin ns++; @(negedge clk); end
    while (eng_ispattern && np < 100) begin np++; @(negedge clk); end
    n_cmp++;
    if (ns != 5 || np != 2) begin
      n_err++; $display("FAIL basic_strobes: got isstring=%0d ispattern=%0d cycles, required 5/2", ns, np);
    end
    while (resp_valid == 2'b00 && w < 200) begin @(negedge clk); w++; end
    n_cmp++;
    if ({resp_valid, resp_match, resp_index, resp_status} !== {2'b01, 1'b1, 5'd2, 2'd0}) begin
      n_err++; $display("FAIL basic_resp: got valid=%b match=%b index=%0d status=%0d, required 01/1/2/0", resp_valid, resp_match, resp_index, resp_status);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_drain: %0d outstanding, required 0", q_res.size()); end
  endtask

  task automatic test_nomatch();
    int w = 0;
    bit ok;
    expect_job(1, "HELLO", "XY", 1'b0);
    load_job(1, "HELLO", "XY");
    while (resp_valid[1] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    n_cmp++;
    if (req_ready[1] !== 1'b0 || resp_valid !== 2'b10) begin
      n_err++; $display("FAIL nomatch_resp: got ready1=%b resp_valid=%b, required 0/10", req_ready[1], resp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready[1] !== 1'b1 || resp_valid !== 2'b00) begin
      n_err++; $display("FAIL nomatch_ready_back: got ready1=%b resp_valid=%b, required 1/00", req_ready[1], resp_valid);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL nomatch_drain: %0d outstanding, required 0", q_res.size()); end
  endtask

  task automatic test_round_robin();
    int w;
    bit ok;
    do_reset();
    expect_job(0, "ABCD", "BC", 1'b0);
    expect_job(1, "WXYZ", "YZ", 1'b0);
    fork
      load_job(0, "ABCD", "BC");
      load_job(1, "WXYZ", "YZ");
    join
    w = 0;
    while (!eng_isstring && w < 50) begin @(negedge clk); w++; end
    n_cmp++;
    if (eng_chardata !== 8'h41) begin n_err++; $display("FAIL rr_tie1_first: got chardata=%h, required 41", eng_chardata); end
    drain(ok);
    expect_job(0, "QRS", "S", 1'b0);
    load_job(0, "QRS", "S");
    drain(ok);
    expect_job(1, "MNOP", "NO", 1'b0);
    expect_job(0, "EFGH", "GH", 1'b0);
    fork
      load_job(0, "EFGH", "GH");
      load_job(1, "MNOP", "NO");
    join
    w = 0;
    while (!eng_isstring && w < 50) begin @(negedge clk); w++; end
    n_cmp++;
    if (eng_chardata !== 8'h4D) begin n_err++; $display("FAIL rr_tie2_first: got chardata=%h, required 4d", eng_chardata); end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rr_drain: %0d outstanding, required 0", q_res.size()); end
  endtask

  task automatic test_timeout();
    int w = 0;
    int cyc = 0;
    bit ok;
    eng_on = 1'b0;
    expect_job(0, "TIMEOUT", "OUT", 1'b1);
    load_job(0, "TIMEOUT", "OUT");
    while (!eng_ispattern && w < 100) begin @(negedge clk); w++; end
    while (eng_ispattern && w < 200) begin @(negedge clk); w++; end
    while (resp_valid == 2'b00 && cyc < 300) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc != TIMEOUT || resp_status !== 2'd1 || resp_match !== 1'b0) begin
      n_err++; $display("FAIL timeout_resp: got %0d cycles status=%0d match=%b, required %0d/1/0", cyc, resp_status, resp_match, TIMEOUT);
    end
    @(negedge clk);
    eng_on = 1'b1;
    expect_job(1, "NEXT", "EX", 1'b0);
    load_job(1, "NEXT", "EX");
    drain(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL timeout_drain: %0d outstanding, required 0", q_res.size()); end
  endtask

  task automatic test_bad_job();
    int w = 0;
    int act = 0;
    int ns = 0;
    bit ok;
    string s40 = "abcdabcdabcdabcdabcdabcdabcdabcdZZZZZZZZ";
    expect_job(0, "", "P", 1'b0);
    load_job(0, "", "P");
    while (resp_valid == 2'b00 && w < 100) begin
      if (eng_isstring || eng_ispattern) act++;
      @(negedge clk); w++;
    end
    n_cmp++;
    if (act != 0 || resp_status !== 2'd2 || resp_valid !== 2'b01) begin
      n_err++; $display("FAIL bad_job: got strobes=%0d status=%0d valid=%b, required 0/2/01", act, resp_status, resp_valid);
    end
    drain(ok);
    expect_job(0, s40, "ZZ", 1'b0);
    load_job(0, s40, "ZZ");
    w = 0;
    while (!eng_isstring && w < 50) begin @(negedge clk); w++; end
    while (eng_isstring && ns < 100) begin ns++; @(negedge clk); end
    n_cmp++;
    if (ns != STR_MAX) begin n_err++; $display("FAIL str_saturate: got %0d string chars, required %0d", ns, STR_MAX); end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bad_drain: %0d outstanding, required 0", q_res.size()); end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    int pulses = 0;
    bit ok;
    load_job(0, "ABCDEFGH", "EF");
    while (!eng_isstring && w < 50) begin @(negedge clk); w++; end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (eng_isstring !== 1'b0 || eng_ispattern !== 1'b0 || req_ready !== 2'b11 || resp_valid !== 2'b00) begin
      n_err++; $display("FAIL mid_reset: got isstring=%b ispattern=%b ready=%b resp=%b, required 0/0/11/00", eng_isstring, eng_ispattern, req_ready, resp_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (resp_valid != 2'b00) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_err++; $display("FAIL mid_no_resp: got %0d resp pulses, required 0", pulses); end
    expect_job(1, "RESET", "SET", 1'b0);
    load_job(1, "RESET", "SET");
    drain(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mid_drain: %0d outstanding, required 0", q_res.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nomatch();
    test_round_robin();
    test_timeout();
    test_bad_job();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sme_job_arbiter.md
Name: sme_job_arbiter

Overview:
- Shares one string-match engine between two requesters.
- Each requester byte-loads a private job: a string of up to STR_MAX chars plus a pattern of up to PAT_MAX chars.
- The block picks pending jobs round-robin and streams each one to the engine on its chardata/isstring/ispattern interface.
- It waits for the engine's valid, then returns match/index/status to the job's owner.

Parameters:
STR_MAX, 32, string buffer depth per requester (chars); lengths saturate here
PAT_MAX, 8, pattern buffer depth per requester (chars)
TIMEOUT, 64, max cycles in WAIT before a job is aborted with timeout status

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-requester byte valid (bit r = requester r)
req_ready  out  2  per-requester ready; byte accepted when valid&ready
req_is_pat  in  2  0 = string byte, 1 = pattern byte
req_last  in  2  marks final pattern byte of the job; ignored on string bytes
req_data  in  16  byte for requester r at [8r+7:8r]
eng_chardata  out  8  char to engine
eng_isstring  out  1  string char strobe
eng_ispattern  out  1  pattern char strobe
eng_valid  in  1  engine result valid
eng_match  in  1  engine match flag
eng_match_index  in  5  engine match index
resp_valid  out  2  one-cycle pulse to the job owner
resp_match  out  1  result match, qualified by resp_valid
resp_index  out  5  match index; 0 when resp_match=0 or status!=0
resp_status  out  2  0 ok, 1 timeout, 2 bad job (empty string or empty pattern)

Behaviour:
Reset values:
- All outputs 0 except req_ready=2'b11.
- Buffers and lengths cleared; state IDLE; last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation aborts everything, drops loaded jobs and generates no response.

Loading (per requester, independent of engine state):
- req_ready[r]=1 while r has no pending or in-service job.
- String bytes go to str_buf[str_len++]. Pattern bytes go to pat_buf[pat_len++].
- Bytes past STR_MAX or PAT_MAX are accepted and discarded; the length saturates.
- A string byte after any pattern byte of the same job is discarded.
- An accepted byte with req_is_pat=1 and req_last=1 sets pending[r] at the next edge, and req_ready[r] drops in that same edge.

State machine (all engine outputs registered):
- IDLE: if any pending, grant round-robin (prefer !last_grant on a tie). Update last_grant and go to SEND_STR.
  - A bad job (str_len==0 or pat_len==0) goes straight to RESP with status 2 and no engine activity.
  - A job completing in the same cycle it would be sampled is seen next cycle.
- SEND_STR: one char per cycle, eng_isstring=1, chars str_buf[0..str_len-1] in order. After the last char go to SEND_PAT.
- SEND_PAT: eng_ispattern=1, chars pat_buf[0..pat_len-1]. Then go to WAIT with isstring=ispattern=chardata=0.
- WAIT: a wait counter starts at 0 and increments each cycle.
  - On eng_valid, capture eng_match and eng_match_index; go to RESP, status 0.
  - If the counter reaches TIMEOUT-1 without eng_valid, go to RESP, status 1, match 0.
  - eng_valid outside WAIT is ignored.
- RESP: for one cycle, resp_valid[owner]=1 with resp_match/resp_index/resp_status. Clear the owner's buffers, lengths and pending; req_ready[owner]=1 from the next cycle. Return to IDLE.
- At least one idle engine cycle (both strobes 0) always separates consecutive jobs.

Latency:
- Last pattern byte accepted at cycle t with the engine idle: first isstring at t+2.
- Job cycles to response = str_len + pat_len + engine latency + 3.

Test Plan:
- Req0 loads "ABCDE" then "CD" (last), engine model in loop -> eng_isstring high 5 cycles (A..E), eng_ispattern 2 cycles (C,D); resp_valid=2'b01, match=1, index=2, status=0.
- Req1 loads "HELLO" then "XY" -> resp_valid=2'b10, match=0, index=0, status=0; req_ready[1] back to 1 the cycle after resp.
- Both requesters complete jobs in the same cycle after reset -> req0 streamed first, then req1. Next simultaneous tie serves req0 again only if req1 was last granted (round-robin alternation checked over 4 jobs).
- Engine stub never asserts eng_valid -> resp_status=1 exactly TIMEOUT=64 cycles after WAIT entry; match=0; next job streams normally.
- Req0 sends a pattern byte with req_last and no string bytes -> resp_status=2 with no eng_isstring/eng_ispattern activity; 40 string bytes -> only the first 32 are streamed.
- Assert reset during SEND_STR -> engine strobes drop immediately, req_ready=2'b11, no resp_valid pulse.
